pipe_sequencer: RTL and testbench
=================================

Name: pipe_sequencer

Overview:
- Central sequencer for the 4-stage mini-core pipeline: F (instruction fetch), D (operand load), E (multi-cycle ALU), W (data-memory writeback).
- Runs a program-load phase that writes instruction memory, then a run phase.
- In the run phase it drives the PC, stalls on ALU busy and on read-after-write hazards, and inserts bubbles.
- Detects halt and drains the pipeline before asserting halted.

Parameters:
- IMEM_DEPTH, 32, instruction-memory entries.
- PC_W, 5, PC / imem address width.
- DADDR_W, 6, data-memory address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load_valid  in  1  loader presents an instruction word this cycle.
- load_last  in  1  qualifies load_valid: final program word.
- load_ready  out  1  sequencer accepts load words (LOAD state only).
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  PC_W  instruction-memory write address.
- imem_raddr  out  PC_W  fetch address (PC).
- id_inst  in  20  instruction in D: [19:18] op, [17:12] src1, [11:6] src2, [5:0] dst.
- d_valid  out  1  id_inst holds a real instruction.
- hold_fd  out  1  freeze the F/D pipeline registers.
- alu_start  out  1  one-cycle pulse: D operands latch into E.
- alu_op  out  2  op of the instruction in E.
- alu_done  in  1  E result ready (is_done).
- wb_en  out  1  data-memory write enable (W stage).
- wb_addr  out  DADDR_W  data-memory write address.
- halted  out  1  program finished, sticky.
- state  out  2  0 LOAD, 1 RUN, 2 DRAIN, 3 HALT.

Behaviour:
- Opcodes: 00 add, 01 sub, 10 mul, 11 halt.
- Reset:
  - state=LOAD; wptr=0; pc=0; prog_len=0.
  - All valid bits 0; every output 0 except load_ready=1.
  - Reset asserted mid-operation aborts immediately; imem contents are not touched.
- LOAD:
  - Each cycle with load_valid: imem_we=1, imem_waddr=wptr (combinational), then wptr++.
  - load_last accepted, or accepted word at wptr=IMEM_DEPTH-1: prog_len=wptr+1, pc=0, go to RUN next cycle.
  - load_ready=0 outside LOAD; load_valid is ignored there.
- Fetch:
  - imem_raddr=pc. Instruction memory read is synchronous, so id_inst for address pc is valid the following cycle, flagged by d_valid.
  - In RUN with hold_fd=0 and pc<prog_len: pc++ and d_valid<=1. Otherwise d_valid<=0, unless hold_fd keeps it.
- Advance D->E:
  - Condition: d_valid, op!=11, E free, and no RAW.
  - E free = e_valid==0 or alu_done==1.
  - RAW = (src1 or src2) equals e_dst with e_valid, or equals w_dst with w_valid.
  - On advance: alu_start=1, e_valid<=1, e_dst<=dst, alu_op<=op.
- hold_fd = d_valid and op!=11 and not advance. While held, pc and d_valid are frozen.
- E completion: alu_done with e_valid means next cycle w_valid=1, wb_en=1, wb_addr=e_dst. W always lasts one cycle. If there is no simultaneous advance, e_valid clears.
- alu_done with e_valid=0 is ignored.
- Halt in D (d_valid, op=11):
  - Fetch stops and d_valid<=0; the halt never enters E.
  - Go to DRAIN.
- pc==prog_len in RUN with D empty: implicit halt, go to DRAIN.
- DRAIN → HALT once e_valid=0 and w_valid=0. halted=1 from the cycle after the last wb_en, and remains until reset.
- Simultaneous events:
  - alu_done plus a new advance in the same cycle: both take effect, giving back-to-back E occupancy.
  - A RAW hit against W takes priority and stalls exactly until W retires.

Test Plan:
- Load {add 1,2→3 ; sub 3,4→5 ; halt} with load_last on word 2 → imem_we on 3 cycles, waddr 0,1,2; state=RUN next cycle; prog_len=3.
- Independent adds (dst 10,11,12, no shared srcs), alu_done 1 cycle after each alu_start → alu_start every cycle; wb_en with wb_addr 10,11,12 on consecutive cycles; hold_fd never high.
- inst0 dst=5, inst1 src1=5 → inst1 alu_start occurs the cycle after inst0's wb_en (wb_addr=5); hold_fd high for every intervening cycle.
- mul with alu_done 4 cycles after start, followed by an independent add → hold_fd high 3 cycles; imem_raddr constant; add alu_start coincides with mul alu_done.
- Load 32 words without load_last, no halt opcode → RUN after the 32nd word; pc runs to 32; halted=1 after the last writeback; state=3.
- rst low during a mul in E → same cycle: all outputs 0, load_ready=1, state=0; wb_en never fires for that mul.

Source files
------------

// File: rtl/pipe_sequencer.sv
// Central sequencer for the F/D/E/W mini-core. It loads instruction memory, then issues
// instructions with ALU-busy and read-after-write stalls, and drains the pipe on halt.
module pipe_sequencer #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = 5,
  parameter int DADDR_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic               imem_we,
  output logic [PC_W-1:0]    imem_waddr,
  output logic [PC_W-1:0]    imem_raddr,
  input  logic [19:0]        id_inst,
  output logic               d_valid,
  output logic               hold_fd,
  output logic               alu_start,
  output logic [1:0]         alu_op,
  input  logic               alu_done,
  output logic               wb_en,
  output logic [DADDR_W-1:0] wb_addr,
  output logic               halted,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b11;

  state_t             cur;
  logic [PC_W:0]      pc;
  logic [PC_W:0]      prog_len;
  logic [PC_W-1:0]    wptr;
  logic               e_valid;
  logic [DADDR_W-1:0] e_dst;

  logic [1:0]         d_op;
  logic [DADDR_W-1:0] d_src1;
  logic [DADDR_W-1:0] d_src2;
  logic [DADDR_W-1:0] d_dst;
  logic               d_halt;
  logic               e_free;
  logic               raw_e;
  logic               raw_w;
  logic               advance;
  logic               e_done;
  logic               load_fire;
  logic               load_end;

  assign d_op   = id_inst[19:18];
  assign d_src1 = DADDR_W'(id_inst[17:12]);
  assign d_src2 = DADDR_W'(id_inst[11:6]);
  assign d_dst  = DADDR_W'(id_inst[5:0]);

  // wb_en/wb_addr double as the W-stage valid bit and destination.
  assign d_halt    = d_valid && (d_op == OP_HALT);
  assign e_free    = !e_valid || alu_done;
  assign raw_e     = e_valid && ((d_src1 == e_dst) || (d_src2 == e_dst));
  assign raw_w     = wb_en && ((d_src1 == wb_addr) || (d_src2 == wb_addr));
  assign advance   = d_valid && (d_op != OP_HALT) && e_free && !raw_e && !raw_w;
  assign hold_fd   = d_valid && (d_op != OP_HALT) && !advance;
  assign alu_start = advance;
  assign e_done    = e_valid && alu_done;

  assign load_ready = (cur == S_LOAD);
  assign load_fire  = rst && (cur == S_LOAD) && load_valid;
  assign load_end   = load_fire && (load_last || (wptr == PC_W'(IMEM_DEPTH - 1)));
  assign imem_we    = load_fire;
  assign imem_waddr = wptr;
  assign imem_raddr = pc[PC_W-1:0];
  assign state      = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= S_LOAD;
      pc       <= '0;
      prog_len <= '0;
      wptr     <= '0;
      d_valid  <= 1'b0;
      e_valid  <= 1'b0;
      e_dst    <= '0;
      alu_op   <= '0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      halted   <= 1'b0;
    end else begin
      wb_en <= e_done;
      if (e_done)
        wb_addr <= e_dst;

      // A completing E slot can be refilled in the same cycle.
      if (advance) begin
        e_valid <= 1'b1;
        e_dst   <= d_dst;
        alu_op  <= d_op;
      end else if (e_done) begin
        e_valid <= 1'b0;
      end

      case (cur)
        S_LOAD: begin
          if (load_fire) begin
            wptr <= wptr + 1'b1;
            if (load_end) begin
              prog_len <= {1'b0, wptr} + (PC_W+1)'(1);
              pc       <= '0;
              cur      <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (d_halt) begin
            d_valid <= 1'b0;
            cur     <= S_DRAIN;
          end else if (hold_fd) begin
            d_valid <= d_valid;
          end else if (pc < prog_len) begin
            pc      <= pc + 1'b1;
            d_valid <= 1'b1;
          end else begin
            d_valid <= 1'b0;
            if (!d_valid)
              cur <= S_DRAIN;
          end
        end

        // Once E is empty, any W still in flight retires this cycle, so halted
        // rises exactly one cycle after the last write-back.
        S_DRAIN: begin
          if (!e_valid) begin
            cur    <= S_HALT;
            halted <= 1'b1;
          end
        end

        default: cur <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: directed programs push expected events into queues,
// and a negedge monitor pops and compares them whenever the DUT presents an output.
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [4:0]  imem_raddr;
  logic [19:0] id_inst = '0;
  logic        d_valid;
  logic        hold_fd;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic        alu_done;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic        halted;
  logic [1:0]  state;

  logic [19:0] load_word;
  logic [19:0] imem [32];
  logic [19:0] prog [32];
  int          alu_cnt = 0;
  int          cyc = 0;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  localparam int K_STATE  = 0;
  localparam int K_HALTED = 1;
  localparam int K_LREADY = 2;
  localparam int K_RADDR  = 3;
  localparam int K_ALUOP  = 4;
  localparam int K_BASE   = 5;
  localparam int K_HOLD   = 6;
  localparam int K_EMPTY  = 7;
  localparam int K_RESET  = 8;

  ev_t exp_wr[$];
  ev_t exp_start[$];
  ev_t exp_wb[$];
  ev_t exp_chk[$];
  ev_t mon_e;

  int errors = 0;
  int checks = 0;
  int hold_cnt = 0;
  int hold_base = 0;
  logic [26:0] snap;

  pipe_sequencer dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_raddr(imem_raddr),
    .id_inst(id_inst), .d_valid(d_valid), .hold_fd(hold_fd),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .wb_en(wb_en), .wb_addr(wb_addr), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction memory whose output register freezes under hold_fd.
  always @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= load_word;
    if (!hold_fd)
      id_inst <= imem[imem_raddr];
  end

  // ALU model: mul completes 4 cycles after alu_start, add/sub after 1.
  always @(posedge clk) begin
    if (alu_start)
      alu_cnt <= (id_inst[19:18] == 2'b10) ? 4 : 1;
    else if (alu_cnt > 0)
      alu_cnt <= alu_cnt - 1;
  end
  assign alu_done = (alu_cnt == 1);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_wr.size() == 0) checkOutput("unexpected imem_we", 1, 0);
      else begin
        mon_e = exp_wr.pop_front();
        checkOutput("imem_we cycle", cyc, mon_e.cyc);
        checkOutput("imem_waddr", int'(imem_waddr), mon_e.val);
      end
    end
    if (alu_start) begin
      if (exp_start.size() == 0) checkOutput("unexpected alu_start", 1, 0);
      else begin
        mon_e = exp_start.pop_front();
        checkOutput("alu_start cycle", cyc, mon_e.cyc);
      end
    end
    if (wb_en) begin
      if (exp_wb.size() == 0) checkOutput("unexpected wb_en", 1, 0);
      else begin
        mon_e = exp_wb.pop_front();
        checkOutput("wb_en cycle", cyc, mon_e.cyc);
        checkOutput("wb_addr", int'(wb_addr), mon_e.val);
      end
    end
    if (hold_fd)
      hold_cnt++;

    while (exp_chk.size() > 0 && exp_chk[0].cyc <= cyc) begin
      mon_e = exp_chk.pop_front();
      case (mon_e.kind)
        K_STATE:  checkOutput("state", int'(state), mon_e.val);
        K_HALTED: checkOutput("halted", int'(halted), mon_e.val);
        K_LREADY: checkOutput("load_ready", int'(load_ready), mon_e.val);
        K_RADDR:  checkOutput("imem_raddr", int'(imem_raddr), mon_e.val);
        K_ALUOP:  checkOutput("alu_op", int'(alu_op), mon_e.val);
        K_BASE:   hold_base = hold_cnt;
        K_HOLD:   checkOutput("hold_fd cycles", hold_cnt - hold_base, mon_e.val);
        K_EMPTY:  checkOutput("pending events", exp_wr.size() + exp_start.size() + exp_wb.size(), mon_e.val);
        K_RESET: begin
          snap = {load_ready, imem_we, imem_waddr, imem_raddr, d_valid, hold_fd, alu_start,
                  alu_op, wb_en, wb_addr, halted, state};
          checkOutput("reset outputs", int'(snap), 1 << 26);
        end
        default: checkOutput("bad check kind", mon_e.kind, 0);
      endcase
    end
  end

  function automatic logic [19:0] mk(input logic [1:0] op, input int s1, input int s2, input int d);
    return {op, 6'(s1), 6'(s2), 6'(d)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) step();
  endtask

  task automatic pushChk(input int c, input int k, input int v);
    exp_chk.push_back('{c, k, v});
  endtask

  task automatic pushStart(input int c);
    exp_start.push_back('{c, 0, 0});
  endtask

  task automatic pushWb(input int c, input int a);
    exp_wb.push_back('{c, 0, a});
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  // Presents prog[0..n-1] on consecutive cycles; run_cyc is the first RUN cycle.
  task automatic applyStimulus(input int n, input bit use_last, output int run_cyc);
    step();
    run_cyc = cyc + n;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_word  = prog[i];
      load_last  = use_last && (i == n - 1);
      exp_wr.push_back('{cyc, 0, i});
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic runStart(input int r);
    pushChk(r, K_BASE, 0);
    pushChk(r, K_STATE, 1);
    pushChk(r, K_LREADY, 0);
  endtask

  task automatic finishRun(input int h, input int holds);
    pushChk(h - 1, K_HALTED, 0);
    pushChk(h, K_HALTED, 1);
    pushChk(h, K_STATE, 3);
    pushChk(h + 1, K_HOLD, holds);
    pushChk(h + 1, K_EMPTY, 0);
    waitUntil(h + 3);
  endtask

  int r;

  initial begin
    rst = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_word = '0;
    repeat (2) step();
    pushChk(cyc, K_RESET, 0);
    step();

    $display("[TB] program with RAW on r3 and explicit halt");
    doReset();
    prog[0] = mk(2'b00, 1, 2, 3);
    prog[1] = mk(2'b01, 3, 4, 5);
    prog[2] = mk(2'b11, 0, 0, 0);
    applyStimulus(3, 1'b1, r);
    runStart(r);
    pushStart(r + 1); pushStart(r + 4);
    pushWb(r + 3, 3); pushWb(r + 6, 5);
    pushChk(r + 5, K_ALUOP, 1);
    finishRun(r + 7, 2);

    $display("[TB] independent adds with implicit halt");
    doReset();
    prog[0] = mk(2'b00, 1, 2, 10);
    prog[1] = mk(2'b00, 3, 4, 11);
    prog[2] = mk(2'b00, 5, 6, 12);
    applyStimulus(3, 1'b1, r);
    runStart(r);
    pushStart(r + 1); pushStart(r + 2); pushStart(r + 3);
    pushWb(r + 3, 10); pushWb(r + 4, 11); pushWb(r + 5, 12);
    pushChk(r + 5, K_STATE, 2);
    finishRun(r + 6, 0);

    $display("[TB] RAW on r5 stalls until write-back retires");
    doReset();
    prog[0] = mk(2'b00, 1, 2, 5);
    prog[1] = mk(2'b00, 5, 6, 7);
    prog[2] = mk(2'b11, 0, 0, 0);
    applyStimulus(3, 1'b1, r);
    runStart(r);
    pushStart(r + 1); pushStart(r + 4);
    pushWb(r + 3, 5); pushWb(r + 6, 7);
    finishRun(r + 7, 2);

    $display("[TB] mul busy stall then independent add");
    doReset();
    prog[0] = mk(2'b10, 1, 2, 20);
    prog[1] = mk(2'b00, 3, 4, 21);
    prog[2] = mk(2'b11, 0, 0, 0);
    applyStimulus(3, 1'b1, r);
    runStart(r);
    pushStart(r + 1); pushStart(r + 5);
    pushWb(r + 6, 20); pushWb(r + 7, 21);
    pushChk(r + 2, K_ALUOP, 2);
    pushChk(r + 2, K_RADDR, 2);
    pushChk(r + 3, K_RADDR, 2);
    pushChk(r + 4, K_RADDR, 2);
    finishRun(r + 8, 3);

    $display("[TB] full 32-word program without load_last");
    doReset();
    for (int i = 0; i < 32; i++) prog[i] = mk(2'b00, 40, 41, i);
    applyStimulus(32, 1'b0, r);
    runStart(r);
    for (int i = 0; i < 32; i++) begin
      pushStart(r + 1 + i);
      pushWb(r + 3 + i, i);
    end
    finishRun(r + 35, 0);

    $display("[TB] reset while mul occupies E");
    doReset();
    prog[0] = mk(2'b10, 1, 2, 30);
    prog[1] = mk(2'b11, 0, 0, 0);
    applyStimulus(2, 1'b1, r);
    runStart(r);
    pushStart(r + 1);
    waitUntil(r + 2);
    rst = 1'b0;
    pushChk(r + 2, K_RESET, 0);
    repeat (2) step();
    rst = 1'b1;
    pushChk(r + 8, K_STATE, 0);
    pushChk(r + 8, K_HALTED, 0);
    pushChk(r + 8, K_LREADY, 1);
    pushChk(r + 8, K_EMPTY, 0);
    waitUntil(r + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
